// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic inter-stage registers of the five-stage
// MIPS core.
//   RESET_PC_DEFAULT : PC value a stage shows after reset
//   LANE_*           : payload lane positions used by the W-stage instance
//   state_e          : occupancy state of a pipe_stage_buf
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam int LANE_ALU   = 0;
    localparam int LANE_PC    = 1;
    localparam int LANE_DM    = 2;
    localparam int LANE_INSTR = 3;
    localparam int LANE_MD    = 4;

    // EMPTY: head invalid; FULL: head valid, skid invalid; SKID: both valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One {data, flag, valid} storage entry of an elastic pipeline stage.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load_i     : capture data_i / flag_i / valid_i (wins over clear_i)
//   clear_i    : drop valid, keep data and flags as they are
//   data_i     : payload to load
//   flag_i     : side-band flags to load
//   valid_i    : valid bit to load
//   data_o     : stored payload
//   flag_o     : stored flags
//   valid_o    : stored valid bit
// -----------------------------------------------------------------------------
module pipe_slot #(
    parameter int                DATA_W   = 32,
    parameter int                FLAG_W   = 1,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [FLAG_W-1:0] flag_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic [FLAG_W-1:0] flag_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] data_q;
    logic [FLAG_W-1:0] flag_q;
    logic              valid_q;

    // Single storage entry. Load takes precedence over clear so the owner can
    // overwrite an entry in the same cycle it would otherwise drop it. A clear
    // keeps the payload so a drained stage still shows its last contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= RST_DATA;
            flag_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            flag_q  <= flag_i;
            valid_q <= valid_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign flag_o  = flag_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Elastic pipeline-stage register with valid/ready handshake, a one-entry skid
// buffer, a PC-preserving flush and a bubble counter.
// Ports:
//   clk, reset : stage clock and synchronous active-high reset
//   flush      : discard held and incoming entries this cycle
//   in_valid   : upstream presents an entry
//   in_ready   : stage can accept (registered, depends on state only)
//   in_data    : LANES x 32-bit payload, lane k at [32k+31:32k]
//   in_flag    : FLAG_W side-band flags
//   out_valid  : head entry valid
//   out_ready  : downstream consumes the head this cycle
//   out_data   : head payload
//   out_flag   : head flags, 0 when the head is a bubble
//   bubble_cnt : number of edges after which out_valid was 0
// -----------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int          LANES    = 5,
    parameter int          FLAG_W   = 2,
    parameter int          PC_LANE  = LANE_PC,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   in_data,
    input  logic [FLAG_W-1:0]     in_flag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_data,
    output logic [FLAG_W-1:0]     out_flag,
    output logic [31:0]           bubble_cnt
);

    localparam int                DATA_W   = 32 * LANES;
    localparam logic [DATA_W-1:0] RST_DATA = DATA_W'(RESET_PC) << (32 * PC_LANE);

    state_e            state_q;
    state_e            state_d;

    logic              accept;
    logic              pop;

    logic              headValid;
    logic [DATA_W-1:0] headData;
    logic [FLAG_W-1:0] headFlag;
    logic              skidValid;
    logic [DATA_W-1:0] skidData;
    logic [FLAG_W-1:0] skidFlag;

    logic              headLoad;
    logic              headClear;
    logic              headValid_d;
    logic [DATA_W-1:0] headData_d;
    logic [FLAG_W-1:0] headFlag_d;
    logic              skidLoad;
    logic              skidClear;

    logic [31:0]       flushPc;
    logic [DATA_W-1:0] flushData;

    logic [31:0]       bubbleCnt_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // State register. Reset lands in EMPTY, which makes in_ready high on the
    // very first edge after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Flush always empties the stage; otherwise occupancy
    // moves up on an accept and down on a pop. SKID cannot accept because
    // in_ready is low there.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (accept && !pop) begin
                        state_d = SKID;
                    end else if (!accept && pop) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (pop) begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // The PC to keep on a flush is that of the oldest instruction being
    // dropped: the head if it holds one, else whatever is arriving, else the
    // PC already shown. All other lanes and the flags become zero.
    always_comb begin
        flushPc = headData[32*PC_LANE +: 32];
        if (!headValid && in_valid) begin
            flushPc = in_data[32*PC_LANE +: 32];
        end
        flushData = '0;
        flushData[32*PC_LANE +: 32] = flushPc;
    end

    // Output / slot-control logic. in_ready is derived from the registered
    // state only so it never sees in_valid or out_ready combinationally. The
    // slot controls steer the head either from the input, from the skid entry
    // (keeping FIFO order) or from the flush bubble.
    always_comb begin
        in_ready    = (state_q != SKID);
        headLoad    = 1'b0;
        headClear   = 1'b0;
        headValid_d = 1'b1;
        headData_d  = in_data;
        headFlag_d  = in_flag;
        skidLoad    = 1'b0;
        skidClear   = 1'b0;
        if (flush) begin
            headLoad    = 1'b1;
            headValid_d = 1'b0;
            headData_d  = flushData;
            headFlag_d  = '0;
            skidClear   = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    headLoad = accept;
                end
                FULL: begin
                    if (accept && pop) begin
                        headLoad = 1'b1;
                    end else if (accept) begin
                        skidLoad = 1'b1;
                    end else if (pop) begin
                        headClear = 1'b1;
                    end
                end
                SKID: begin
                    if (pop) begin
                        headLoad    = 1'b1;
                        headValid_d = skidValid;
                        headData_d  = skidData;
                        headFlag_d  = skidFlag;
                        skidClear   = 1'b1;
                    end
                end
                default: begin
                    headClear = 1'b1;
                    skidClear = 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(
        .DATA_W   (DATA_W),
        .FLAG_W   (FLAG_W),
        .RST_DATA (RST_DATA)
    ) u_head (
        .clk     (clk),
        .reset   (reset),
        .load_i  (headLoad),
        .clear_i (headClear),
        .data_i  (headData_d),
        .flag_i  (headFlag_d),
        .valid_i (headValid_d),
        .data_o  (headData),
        .flag_o  (headFlag),
        .valid_o (headValid)
    );

    pipe_slot #(
        .DATA_W   (DATA_W),
        .FLAG_W   (FLAG_W),
        .RST_DATA ('0)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skidLoad),
        .clear_i (skidClear),
        .data_i  (in_data),
        .flag_i  (in_flag),
        .valid_i (1'b1),
        .data_o  (skidData),
        .flag_o  (skidFlag),
        .valid_o (skidValid)
    );

    // Bubble counter. The post-edge head is invalid exactly when the next
    // state is EMPTY, flush edges included. The reset edge itself only clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubbleCnt_q <= '0;
        end else if (state_d == EMPTY) begin
            bubbleCnt_q <= bubbleCnt_q + 32'd1;
        end
    end

    assign out_valid  = headValid;
    assign out_data   = headData;
    assign out_flag   = headValid ? headFlag : '0;
    assign bubble_cnt = bubbleCnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
// Directed self-checking bench for pipe_stage_buf with default parameters.
// Each entry's payload is derived from its PC so every lane can be predicted.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int LANES  = 5;
    localparam int FLAG_W = 2;
    localparam int DW     = 32 * LANES;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [FLAG_W-1:0] in_flag;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [FLAG_W-1:0] out_flag;
    logic [31:0]       bubble_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_buf #(
        .LANES    (LANES),
        .FLAG_W   (FLAG_W),
        .PC_LANE  (1),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_flag    (in_flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_flag   (out_flag),
        .bubble_cnt (bubble_cnt)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Payload for an entry: every lane is a distinct function of the PC,
    // with the PC itself in lane 1
    function automatic logic [DW-1:0] makeData(input logic [31:0] pc);
        logic [DW-1:0] d;
        d[31:0]    = pc ^ 32'hA5A5_0000;
        d[63:32]   = pc;
        d[95:64]   = pc + 32'h0000_0100;
        d[127:96]  = ~pc;
        d[159:128] = pc << 4;
        return d;
    endfunction

    function automatic logic [FLAG_W-1:0] makeFlag(input logic [31:0] pc);
        return pc[3:2];
    endfunction

    // Bubble payload: only the PC lane non-zero
    function automatic logic [DW-1:0] pcOnly(input logic [31:0] pc);
        logic [DW-1:0] d;
        d = '0;
        d[63:32] = pc;
        return d;
    endfunction

    // Drive all inputs for the next edge
    task automatic applyStimulus(input logic rst, input logic fl, input logic vld,
                                 input logic [31:0] pc, input logic ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = vld;
        in_data   = makeData(pc);
        in_flag   = makeFlag(pc);
        out_ready = ordy;
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Head view check: valid, payload, flags, ready
    task automatic checkHead(input string tag, input logic expValid,
                             input logic [DW-1:0] expData,
                             input logic [FLAG_W-1:0] expFlag, input logic expReady);
        checkOutput({tag, ".out_valid"}, DW'(out_valid), DW'(expValid));
        checkOutput({tag, ".out_data"}, out_data, expData);
        checkOutput({tag, ".out_flag"}, DW'(out_flag), DW'(expFlag));
        checkOutput({tag, ".in_ready"}, DW'(in_ready), DW'(expReady));
    endtask

    initial begin
        logic [31:0] pcs [4];
        pcs[0] = 32'h0000_3000;
        pcs[1] = 32'h0000_3004;
        pcs[2] = 32'h0000_3008;
        pcs[3] = 32'h0000_300c;

        $display("[TB] reset then idle");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        checkHead("idle", 1'b0, pcOnly(32'h0000_3000), 2'b00, 1'b1);
        checkOutput("idle.bubble_cnt", DW'(bubble_cnt), DW'(32'd3));

        $display("[TB] streaming");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, pcs[i], 1'b1);
            tick();
            checkHead($sformatf("stream%0d", i), 1'b1, makeData(pcs[i]),
                      makeFlag(pcs[i]), 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkHead("drain", 1'b0, makeData(32'h0000_300c), 2'b00, 1'b1);
        checkOutput("drain.bubble_cnt", DW'(bubble_cnt), DW'(32'd4));

        $display("[TB] backpressure");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0);
        tick();
        checkHead("bp.head", 1'b1, makeData(32'h0000_3000), makeFlag(32'h0000_3000), 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3004, 1'b0);
        tick();
        checkHead("bp.skid", 1'b1, makeData(32'h0000_3000), makeFlag(32'h0000_3000), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3008, 1'b0);
        tick();
        checkHead("bp.hold", 1'b1, makeData(32'h0000_3000), makeFlag(32'h0000_3000), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3008, 1'b1);
        tick();
        checkHead("bp.pop1", 1'b1, makeData(32'h0000_3004), makeFlag(32'h0000_3004), 1'b1);
        tick();
        checkHead("bp.pop2", 1'b1, makeData(32'h0000_3008), makeFlag(32'h0000_3008), 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkHead("bp.empty", 1'b0, makeData(32'h0000_3008), 2'b00, 1'b1);
        checkOutput("bp.bubble_cnt", DW'(bubble_cnt), DW'(32'd5));

        $display("[TB] flush in SKID");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3010, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3014, 1'b0);
        tick();
        checkHead("fs.skid", 1'b1, makeData(32'h0000_3010), makeFlag(32'h0000_3010), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_3018, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("fs.flush", 1'b0, pcOnly(32'h0000_3010), 2'b00, 1'b1);
        checkOutput("fs.bubble_cnt", DW'(bubble_cnt), DW'(32'd6));
        tick();
        checkHead("fs.after", 1'b0, pcOnly(32'h0000_3010), 2'b00, 1'b1);

        $display("[TB] flush with empty stage");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_3040, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkHead("fe.flush", 1'b0, pcOnly(32'h0000_3040), 2'b00, 1'b1);
        checkOutput("fe.bubble_cnt", DW'(bubble_cnt), DW'(32'd8));

        $display("[TB] reset mid-backpressure");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3050, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3054, 1'b0);
        tick();
        checkHead("rb.skid", 1'b1, makeData(32'h0000_3050), makeFlag(32'h0000_3050), 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("rb.reset", 1'b0, pcOnly(32'h0000_3000), 2'b00, 1'b1);
        checkOutput("rb.bubble_cnt", DW'(bubble_cnt), DW'(32'd0));
        tick();
        checkHead("rb.after", 1'b0, pcOnly(32'h0000_3000), 2'b00, 1'b1);
        checkOutput("rb.after.bubble_cnt", DW'(bubble_cnt), DW'(32'd1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
